// File: rtl/rca_mp_sequencer_if.sv
// Beat-stream bundle for rca_mp_sequencer: operand input stream and registered result stream.
// The in_sub member exists only when RCA_SEQ_SUB_EN is defined.
interface rca_mp_sequencer_if #(
  parameter int unsigned N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         in_cin;
  logic         in_last;
`ifdef RCA_SEQ_SUB_EN
  logic         in_sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_last;
  logic         out_cout;
  logic         err_trunc;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_last,
`ifdef RCA_SEQ_SUB_EN
    output in_sub,
`endif
    output out_ready,
    input  in_ready, out_valid, out_sum, out_last, out_cout, err_trunc
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_last,
`ifdef RCA_SEQ_SUB_EN
    input  in_sub,
`endif
    input  out_ready,
    output in_ready, out_valid, out_sum, out_last, out_cout, err_trunc
  );
endinterface

// File: rtl/rca_mp_sequencer.sv
// Multi-precision add sequencer around an external N-bit ripple-carry adder.
// Optional subtract mode (in_sub) is enabled by defining RCA_SEQ_SUB_EN.
module rca_mp_sequencer #(
  parameter int unsigned N         = 8,
  parameter int unsigned MAX_BEATS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rca_mp_sequencer_if.slave    bus,
  output logic [N-1:0]         adder_a,
  output logic [N-1:0]         adder_b,
  output logic                 adder_cin,
  input  logic [N-1:0]         adder_sum,
  input  logic                 adder_cout
);

  localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic             carry_q;
  logic             first;
  logic             sub;
  logic             accept;
  logic             eff_last;
`ifdef RCA_SEQ_SUB_EN
  logic             sub_q;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: a word ends on any accepted beat whose effective last is set
  always_comb begin
    state_d = state_q;
    if (accept) state_d = eff_last ? IDLE : ACTIVE;
  end

  // Handshake and adder drive
  always_comb begin
    first        = (state_q == IDLE);
`ifdef RCA_SEQ_SUB_EN
    sub          = first ? bus.in_sub : sub_q;
`else
    sub          = 1'b0;
`endif
    bus.in_ready = !bus.out_valid || bus.out_ready;
    accept       = bus.in_valid && bus.in_ready;
    eff_last     = bus.in_last || (count_q == CNT_W'(MAX_BEATS - 1));
    adder_a      = bus.in_a;
    adder_b      = sub ? ~bus.in_b : bus.in_b;
    if (first) adder_cin = sub ? 1'b1 : bus.in_cin;
    else       adder_cin = carry_q;
  end

  // Result register, carry chain, beat count and sticky truncation flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_last  <= 1'b0;
      bus.out_cout  <= 1'b0;
      bus.err_trunc <= 1'b0;
      carry_q       <= 1'b0;
      count_q       <= '0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_sum   <= adder_sum;
      bus.out_last  <= eff_last;
      bus.out_cout  <= eff_last ? adder_cout : 1'b0;
      carry_q       <= adder_cout;
      count_q       <= eff_last ? '0 : count_q + CNT_W'(1);
      if (eff_last && !bus.in_last) bus.err_trunc <= 1'b1;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef RCA_SEQ_SUB_EN
  // Subtract mode is latched on the first beat and held for the word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              sub_q <= 1'b0;
    else if (accept && first) sub_q <= bus.in_sub;
  end
`endif

endmodule

// File: tb/tb_rca_mp_sequencer.sv
// Directed bench for rca_mp_sequencer with a behavioural N-bit adder attached.
// Define RCA_SEQ_SUB_EN to also exercise subtract mode.
module tb_rca_mp_sequencer;

  localparam int unsigned N         = 8;
  localparam int unsigned MAX_BEATS = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] adder_a;
  logic [N-1:0] adder_b;
  logic [N-1:0] adder_sum;
  logic         adder_cin;
  logic         adder_cout;

  int n_checks = 0;
  int n_errors = 0;

  rca_mp_sequencer_if #(.N(N)) bus ();

  rca_mp_sequencer #(.N(N), .MAX_BEATS(MAX_BEATS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .adder_cin  (adder_cin),
    .adder_sum  (adder_sum),
    .adder_cout (adder_cout)
  );

  // Attached ripple-carry adder
  assign {adder_cout, adder_sum} = (N+1)'(adder_a) + (N+1)'(adder_b) + (N+1)'(adder_cin);

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic last);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
  endtask

  // One accepted beat: checks the carry fed to the adder, then clocks it in
  task automatic beat(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic last, input logic exp_cin);
`ifdef RCA_SEQ_SUB_EN
    bus.in_sub = 1'b0;
`endif
    drive(a, b, cin, last);
    #1;
    chk({tag, "_cin"}, 8'(adder_cin), 8'(exp_cin));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [7:0] sum, input logic last, input logic cout);
    chk({tag, "_valid"}, 8'(bus.out_valid), 8'd1);
    chk({tag, "_sum"},   bus.out_sum,       sum);
    chk({tag, "_last"},  8'(bus.out_last),  8'(last));
    chk({tag, "_cout"},  8'(bus.out_cout),  8'(cout));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, 8'(bus.out_valid), 8'd0);
    chk({tag, "_sum"},   bus.out_sum,       8'h00);
    chk({tag, "_last"},  8'(bus.out_last),  8'd0);
    chk({tag, "_cout"},  8'(bus.out_cout),  8'd0);
    chk({tag, "_err"},   8'(bus.err_trunc), 8'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
`ifdef RCA_SEQ_SUB_EN
    bus.in_sub    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    chk("rst_in_ready", 8'(bus.in_ready), 8'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-beat word with carry-in: FF+01+1 = 1_01
    beat("t1", 8'hFF, 8'h01, 1'b1, 1'b1, 1'b1);
    check_out("t1", 8'h01, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("t1_drain", 8'(bus.out_valid), 8'd0);

    // Two beats back to back, carry chained into beat 1
    beat("t2b0", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    check_out("t2b0", 8'h00, 1'b0, 1'b0);
    beat("t2b1", 8'h01, 8'h00, 1'b0, 1'b1, 1'b1);
    check_out("t2b1", 8'h02, 1'b1, 1'b0);

    // Same word with a 3-cycle output stall after beat 0
    beat("t3b0", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    drive(8'h01, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_stall_ready", 8'(bus.in_ready), 8'd0);
      chk("t3_stall_sum", bus.out_sum, 8'h00);
      chk("t3_stall_last", 8'(bus.out_last), 8'd0);
      @(posedge clk);
    end
    #1;
    bus.out_ready = 1'b1;
    beat("t3b1", 8'h01, 8'h00, 1'b0, 1'b1, 1'b1);
    check_out("t3b1", 8'h02, 1'b1, 1'b0);

    // Five beats without in_last: forced termination at beat 3
    chk("t4_err_pre", 8'(bus.err_trunc), 8'd0);
    beat("t4b0", 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1);
    check_out("t4b0", 8'h00, 1'b0, 1'b0);
    beat("t4b1", 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
    check_out("t4b1", 8'h00, 1'b0, 1'b0);
    beat("t4b2", 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
    check_out("t4b2", 8'h00, 1'b0, 1'b0);
    chk("t4_err_mid", 8'(bus.err_trunc), 8'd0);
    beat("t4b3", 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
    check_out("t4b3", 8'h00, 1'b1, 1'b1);
    chk("t4_err_set", 8'(bus.err_trunc), 8'd1);
    beat("t4b4", 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
    check_out("t4b4", 8'hFF, 1'b0, 1'b0);
    chk("t4_err_sticky", 8'(bus.err_trunc), 8'd1);

    // Reset mid-word with carry_q=1 pending
    beat("t5b0", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    check_out("t5b0", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset("t5_rst");
    @(negedge clk);
    rst_n = 1'b1;
    beat("t5b1", 8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
    check_out("t5b1", 8'h01, 1'b1, 1'b0);

`ifdef RCA_SEQ_SUB_EN
    // Subtract 0x0100 - 0x0001 = 0x00FF, no borrow; in_sub dropped on beat 1 to show it is held
    bus.in_sub = 1'b1;
    drive(8'h00, 8'h01, 1'b0, 1'b0);
    #1;
    chk("t6b0_cin", 8'(adder_cin), 8'd1);
    chk("t6b0_b", adder_b, 8'hFE);
    @(posedge clk);
    #1;
    check_out("t6b0", 8'hFF, 1'b0, 1'b0);
    bus.in_sub = 1'b0;
    drive(8'h01, 8'h00, 1'b0, 1'b1);
    #1;
    chk("t6b1_cin", 8'(adder_cin), 8'd0);
    chk("t6b1_b", adder_b, 8'hFF);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_out("t6b1", 8'h00, 1'b1, 1'b1);
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rca_mp_sequencer.md
Name: rca_mp_sequencer

Overview:
- Multi-precision add sequencer that sits in front of and behind the N-bit ripple-carry adder.
- Accepts wide operands as a valid/ready stream of N-bit beats, least-significant beat first.
- Drives the adder's a/b/cin, registers its sum, and chains the carry across beats.
- Emits a registered result stream plus the final carry-out on the last beat.

Parameters:
- N, 8, beat width in bits; must match the attached adder width.
- MAX_BEATS, 4, maximum beats per word, >= 1.
- CNT_W, $clog2(MAX_BEATS+1), beat counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_a  in  N  operand A beat.
- in_b  in  N  operand B beat.
- in_cin  in  1  carry-in; sampled only on the first beat of a word.
- in_last  in  1  marks the final beat of a word.
- adder_a  out  N  to adder a; equals in_a.
- adder_b  out  N  to adder b; equals in_b.
- adder_cin  out  1  to adder cin; first beat = in_cin, otherwise carry_q.
- adder_sum  in  N  from adder sum (combinational return).
- adder_cout  in  1  from adder cout (combinational return).
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream ready.
- out_sum  out  N  registered sum beat.
- out_last  out  1  final beat of word.
- out_cout  out  1  final carry-out; meaningful only when out_last=1, else 0.
- err_trunc  out  1  sticky: a word was force-terminated at MAX_BEATS.

Behaviour:
- Reset (async assert, rst_n low):
  - out_valid=0, out_sum=0, out_last=0, out_cout=0, err_trunc=0.
  - carry_q=0, beat count=0, state=IDLE.
- States:
  - IDLE: no word in progress.
  - ACTIVE: at least one beat of the current word accepted, last not yet accepted.
- Output register, depth 1:
  - in_ready = !out_valid || out_ready.
  - No combinational path from in_valid to in_ready.
- Accept = in_valid && in_ready. On accept, next edge:
  - out_valid=1.
  - out_sum=adder_sum.
  - carry_q=adder_cout.
  - count increments.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 beat/cycle while out_ready is held high.
- Carry source for adder_cin:
  - IDLE: in_cin.
  - ACTIVE: carry_q.
- Last handling (eff_last = in_last || count==MAX_BEATS-1):
  - On accepting a beat with eff_last: out_last=1, out_cout=adder_cout, state→IDLE, count→0.
  - Otherwise: out_last=0, out_cout=0, state→ACTIVE.
- Forced termination: if eff_last is true but in_last=0, set err_trunc. err_trunc clears only on reset. The next beat starts a new word and uses in_cin.
- MAX_BEATS=1: every beat is a complete word.
- Output stall: out_valid && !out_ready holds out_sum/out_last/out_cout stable and in_ready=0.
- Output drain: out_ready with no accept clears out_valid on the next edge.
- Simultaneous drain and accept: out_valid stays 1 and is loaded with the new beat.
- Reset mid-word: partial carry and count are discarded. The first beat after reset is treated as a new word.
- Arithmetic is modulo 2^N per beat. No extra width beyond the single carry bit.

Optional Feature:
- Macro: RCA_SEQ_SUB_EN.
- With the macro defined:
  - Extra input port in_sub (1 bit), sampled on the first beat and held for the whole word.
  - When in_sub=1: adder_b = ~in_b, and first-beat adder_cin = 1 (in_cin ignored). Result is A-B.
  - out_cout=1 means no borrow.
- Without the macro: in_sub is absent and the block only adds.

Test Plan (N=8, MAX_BEATS=4 unless noted):
- Single beat in_a=FF, in_b=01, in_cin=1, in_last=1, out_ready=1 -> next cycle out_sum=01, out_last=1, out_cout=1.
- Two beats {a=FF,b=01,cin=0,last=0}, {a=01,b=00,last=1} -> beat 0 out_sum=00, out_cout=0; beat 1 adder_cin=1, out_sum=02, out_last=1, out_cout=0.
- Same two beats with out_ready=0 for 3 cycles after beat 0 -> in_ready=0 during the stall; out_sum=00 held stable; beat 1 result unchanged after release.
- Five beats, in_last=0 throughout -> 4th output has out_last=1 and err_trunc=1; 5th beat uses in_cin as its carry.
- rst_n low after beat 0 of a 2-beat word (carry_q=1) -> all outputs 0; next beat {a=01,b=00,cin=0,last=1} gives out_sum=01.
- With RCA_SEQ_SUB_EN: in_sub=1, beats {a=00,b=01}, {a=01,b=00,last=1} -> out_sum=FF then 00; final out_cout=1.
